// File: rtl/axi_rd_arbiter_pkg.sv
// axi_rd_arbiter_pkg: shared IDs, request encodings, AR state encoding and field helpers for the read arbiter
package axi_rd_arbiter_pkg;

    localparam logic [3:0] ID_ICACHE  = 4'd0;
    localparam logic [3:0] ID_DCACHE  = 4'd1;
    localparam logic [3:0] ID_UNCACHE = 4'd2;

    localparam int         LINE_BEATS = 4;
    localparam logic [7:0] LINE_LEN   = 8'(LINE_BEATS - 1);

    localparam logic [2:0] RD_TYPE_BYTE = 3'b000;
    localparam logic [2:0] RD_TYPE_HALF = 3'b001;
    localparam logic [2:0] RD_TYPE_WORD = 3'b010;
    localparam logic [2:0] RD_TYPE_LINE = 3'b100;

    localparam logic [0:0] AR_IDLE = 1'b0;
    localparam logic [0:0] AR_SEND = 1'b1;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Source indices double as bit positions in the eligibility/grant vectors
    localparam logic [1:0] SRC_I = 2'd0;
    localparam logic [1:0] SRC_D = 2'd1;
    localparam logic [1:0] SRC_U = 2'd2;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } ar_req_t;

    function automatic logic [1:0] src_next(input logic [1:0] s);
        return s == SRC_U ? SRC_I : s + 2'd1;
    endfunction

    function automatic logic [7:0] rd_arlen(input logic [2:0] t);
        return t == RD_TYPE_LINE ? LINE_LEN : 8'd0;
    endfunction

    function automatic logic [2:0] rd_arsize(input logic [2:0] t);
        return t == RD_TYPE_LINE ? 3'b010 : {1'b0, t[1:0]};
    endfunction

endpackage

// File: rtl/axi_rd_prio_sel.sv
// axi_rd_prio_sel: one-hot grant among icache/dcache/uncached sources.
// Fixed priority dcache > uncached > icache; round-robin when AXI_RD_ARB_RR_EN is defined.
module axi_rd_prio_sel
    import axi_rd_arbiter_pkg::*;
(
`ifdef AXI_RD_ARB_RR_EN
    input  logic       clk,
    input  logic       reset,
`endif
    input  logic [2:0] elig,
    output logic [2:0] grant
);

`ifdef AXI_RD_ARB_RR_EN
    logic [1:0] ptr;
    logic [1:0] c1;
    logic [1:0] c2;
    logic [1:0] sel;

    // Scan starts one past the last grant; the last-granted source gets lowest priority
    always_comb begin
        c1    = src_next(ptr);
        c2    = src_next(c1);
        sel   = elig[c1] ? c1 : elig[c2] ? c2 : ptr;
        grant = |elig ? 3'b001 << sel : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (reset)
            ptr <= SRC_I;
        else if (|elig)
            ptr <= sel;
    end
`else
    always_comb
        grant = elig[SRC_D] ? 3'b010 : elig[SRC_U] ? 3'b100 : elig[SRC_I] ? 3'b001 : 3'b000;
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: merges icache/dcache refill and uncached reads onto one AXI AR channel and steers R beats by rid.
// Optional round-robin arbitration via AXI_RD_ARB_RR_EN.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        icache_rd_req,
    input  logic [2:0]  icache_rd_type,
    input  logic [31:0] icache_rd_addr,
    output logic        icache_rd_rdy,
    output logic        icache_ret_valid,
    output logic        icache_ret_last,
    output logic [31:0] icache_ret_data,
    input  logic        dcache_rd_req,
    input  logic [2:0]  dcache_rd_type,
    input  logic [31:0] dcache_rd_addr,
    output logic        dcache_rd_rdy,
    output logic        dcache_ret_valid,
    output logic        dcache_ret_last,
    output logic [31:0] dcache_ret_data,
    input  logic        unc_req,
    input  logic [1:0]  unc_size,
    input  logic [31:0] unc_addr,
    output logic        unc_addr_ok,
    output logic        unc_data_ok,
    output logic [31:0] unc_rdata,
    input  logic        wbuf_busy,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    logic [0:0] state;
    ar_req_t    ar_q;
    ar_req_t    ar_d;
    logic       os_i;
    logic       os_d;
    logic       os_u;
    logic [2:0] elig;
    logic [2:0] grant;
    logic       r_done;
    logic       unused_rresp;

    // Data-side reads wait for the write buffer so a load never overtakes a pending store
    assign elig = state == AR_IDLE ? {unc_req & ~os_u & ~wbuf_busy,
                                      dcache_rd_req & ~os_d & ~wbuf_busy,
                                      icache_rd_req & ~os_i} : 3'b000;

    axi_rd_prio_sel u_sel (
`ifdef AXI_RD_ARB_RR_EN
        .clk   (clk),
        .reset (reset),
`endif
        .elig  (elig),
        .grant (grant)
    );

    assign icache_rd_rdy = grant[SRC_I];
    assign dcache_rd_rdy = grant[SRC_D];
    assign unc_addr_ok   = grant[SRC_U];

    always_comb begin
        ar_d.id   = grant[SRC_D] ? ID_DCACHE : grant[SRC_U] ? ID_UNCACHE : ID_ICACHE;
        ar_d.addr = grant[SRC_D] ? dcache_rd_addr : grant[SRC_U] ? unc_addr : icache_rd_addr;
        ar_d.len  = grant[SRC_D] ? rd_arlen(dcache_rd_type) : grant[SRC_U] ? 8'd0 : rd_arlen(icache_rd_type);
        ar_d.size = grant[SRC_D] ? rd_arsize(dcache_rd_type) : grant[SRC_U] ? {1'b0, unc_size} : rd_arsize(icache_rd_type);
    end

    assign r_done = rvalid & rlast;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= AR_IDLE;
            ar_q  <= '0;
            os_i  <= 1'b0;
            os_d  <= 1'b0;
            os_u  <= 1'b0;
        end else begin
            if (|grant) begin
                state <= AR_SEND;
                ar_q  <= ar_d;
            end else if (state == AR_SEND && arready) begin
                state <= AR_IDLE;
            end
            os_i <= grant[SRC_I] | (os_i & ~(r_done & rid == ID_ICACHE));
            os_d <= grant[SRC_D] | (os_d & ~(r_done & rid == ID_DCACHE));
            os_u <= grant[SRC_U] | (os_u & ~(r_done & rid == ID_UNCACHE));
        end
    end

    assign arvalid = state == AR_SEND;
    assign arid    = ar_q.id;
    assign araddr  = ar_q.addr;
    assign arlen   = ar_q.len;
    assign arsize  = ar_q.size;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    // R path is a pure steering mux; beats with an unknown rid simply match no port
    assign rready           = 1'b1;
    assign icache_ret_valid = rvalid & rid == ID_ICACHE;
    assign icache_ret_last  = rlast;
    assign icache_ret_data  = rdata;
    assign dcache_ret_valid = rvalid & rid == ID_DCACHE;
    assign dcache_ret_last  = rlast;
    assign dcache_ret_data  = rdata;
    assign unc_data_ok      = r_done & rid == ID_UNCACHE;
    assign unc_rdata        = rdata;
    assign unused_rresp     = ^rresp;

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Read-side front end of the AXI bridge. Sits directly downstream of the icache refill port, the dcache refill port and the uncached data read path.
- Arbitrates the three requesters onto one AXI AR channel, issuing 4-beat line bursts for cache refills and single beats for uncached loads.
- Steers returning R beats back to the owning requester by rid.
- Allows up to one outstanding transaction per source, so up to three in flight in total.

Parameters:
- ID_ICACHE, 4'd0, arid used for icache refills.
- ID_DCACHE, 4'd1, arid used for dcache refills.
- ID_UNCACHE, 4'd2, arid used for uncached data reads.
- LINE_BEATS, 4, beats per cache line; arlen = LINE_BEATS-1.

Ports:
- clk  in  1  Clock; single clock domain.
- reset  in  1  Synchronous, active-high reset.
- icache_rd_req  in  1  icache refill request.
- icache_rd_type  in  3  Request type; 3'b100 = line.
- icache_rd_addr  in  32  Line-aligned physical address.
- icache_rd_rdy  out  1  Request accepted this cycle when high together with icache_rd_req.
- icache_ret_valid  out  1  Refill beat valid.
- icache_ret_last  out  1  Last refill beat.
- icache_ret_data  out  32  Refill beat data.
- dcache_rd_req  in  1  dcache refill request.
- dcache_rd_type  in  3  Request type.
- dcache_rd_addr  in  32  Physical address.
- dcache_rd_rdy  out  1  Request accepted.
- dcache_ret_valid  out  1  Refill beat valid.
- dcache_ret_last  out  1  Last refill beat.
- dcache_ret_data  out  32  Refill beat data.
- unc_req  in  1  Uncached load request (reads only).
- unc_size  in  2  0 = byte, 1 = half, 2 = word.
- unc_addr  in  32  Physical address.
- unc_addr_ok  out  1  Uncached request accepted.
- unc_data_ok  out  1  Uncached load data returned.
- unc_rdata  out  32  Uncached load data.
- wbuf_busy  in  1  Write path holds un-acknowledged data writes; blocks data-side reads.
- arid  out  4  AXI read ID.
- araddr  out  32  AXI read address.
- arlen  out  8  Burst length minus one.
- arsize  out  3  Bytes per beat (log2).
- arburst  out  2  Burst type.
- arlock  out  2  Lock; tied 0.
- arcache  out  4  Cache attributes; tied 0.
- arprot  out  3  Protection; tied 0.
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rid  in  4  Returned read ID.
- rdata  in  32  Returned read data.
- rresp  in  2  Read response; ignored.
- rlast  in  1  Last beat of burst.
- rvalid  in  1  R valid.
- rready  out  1  R ready.

Behaviour:
- AR state machine has two states: AR_IDLE and AR_SEND.
- Reset values:
  - State is AR_IDLE; arvalid = 0.
  - araddr, arid and arlen are 0.
  - All outstanding flags (os_i, os_d, os_u) are 0.
  - rready = 1 permanently after reset.
- Eligibility in AR_IDLE:
  - A source is eligible when its req is high and its os flag is clear.
  - dcache and uncached requests are additionally ineligible while wbuf_busy = 1.
- Priority is fixed: dcache > uncached > icache.
- The *_rd_rdy / unc_addr_ok outputs are combinational. Only the selected source's ready is high; every other source sees 0.
- On the accept cycle:
  - Latch the AR fields and set the source's os flag.
  - Next state is AR_SEND, with arvalid = 1 the following cycle. Accept-to-arvalid latency is 1 cycle.
- AR_SEND:
  - Hold all AR fields stable until arvalid & arready, then return to AR_IDLE.
  - No new accept occurs in the arready cycle; minimum spacing between accepts is 2 cycles.
- Field encoding:
  - rd_type 3'b100: arlen = 3, arsize = 3'b010.
  - rd_type 000/001/010: arlen = 0, arsize = {1'b0, rd_type[1:0]}.
  - Uncached requests: arlen = 0, arsize = {1'b0, unc_size}.
  - arburst = 2'b01 always.
- R return routing is combinational, with no buffering:
  - ret_valid = rvalid & (rid == own ID).
  - ret_last = rlast.
  - ret_data = rdata.
- The uncached source gets unc_data_ok = rvalid & (rid == ID_UNCACHE) & rlast.
- An os flag clears on the cycle its own ID's rvalid & rlast arrives.
- An accept and an R-last for the same source in the same cycle cannot occur (os blocks the accept). R-last for other sources coexists freely with an accept.
- R beats with an unknown rid are dropped. rready stays high regardless.
- Reset asserted mid-burst:
  - All state clears.
  - Stale R beats arriving afterwards are routed by rid as usual; the owners must also be in reset.

Optional Feature:
- Macro: AXI_RD_ARB_RR_EN.
- Defined: priority rotates round-robin among the three sources.
  - A 2-bit last-grant pointer resets to icache.
  - The next grant goes to the first eligible source after the pointer, in order dcache → uncached → icache.
- Undefined: fixed priority as stated in Behaviour; no pointer register exists.

Decomposition:
- Shared package holds:
  - The ID constants.
  - RD_TYPE_BYTE/HALF/WORD/LINE encodings.
  - AR_IDLE/AR_SEND state encoding.
  - AXI_BURST_INCR.
- One natural sub-module, axi_rd_prio_sel: the combinational 3-way selector, which contains the optional round-robin pointer.

Test Plan:
- icache line request at 0x1C000000, arready immediate → arvalid the cycle after rd_rdy, arid = 0, arlen = 3, arsize = 2; 4 R beats with rid = 0 → icache_ret_valid ×4, ret_last only on beat 4, os_i clears.
- dcache and icache request in the same cycle → dcache_rd_rdy = 1 and icache_rd_rdy = 0; icache accepted 2+ cycles later once AR_SEND ends.
- Uncached byte read at 0xBFAF8000, unc_size = 0 → arlen = 0, arsize = 0, arid = 2; R beat with rdata = 0x000000A5 → unc_data_ok = 1, unc_rdata = 0x000000A5.
- wbuf_busy = 1 with dcache_rd_req and icache_rd_req high → only icache granted; dcache granted the cycle after wbuf_busy falls.
- Interleaved R returns (rid 1, rid 0, rid 1, …) with icache and dcache both outstanding → each beat steered to the correct port only, with no cross-valid.
- arready held low 5 cycles, then reset asserted → arvalid = 0 and all os flags = 0 the next cycle; a fresh request is accepted after reset deasserts.
